// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU hold registers, up to NCDB grants per cycle, registered broadcast.
// Define CDB_ROTATE_EN for a rotating priority pointer; otherwise priority is static (FU 0 highest).
module cdb_arbiter #(
  parameter int PR_W = 6,
  parameter int NFU  = 8,
  parameter int NCDB = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NFU-1:0]             fu_done,
  input  logic [NFU-1:0][PR_W-1:0]   fu_dest_pr,
  input  logic [NFU-1:0][31:0]       fu_value,
  output logic [NFU-1:0]             fu_ready,
  output logic [NCDB-1:0]            cdb_valid,
  output logic [NCDB-1:0][PR_W-1:0]  cdb_tag,
  output logic [NCDB-1:0][31:0]      cdb_value,
  output logic [NFU-1:0]             pending
);
  localparam int PTR_W = (NFU > 1) ? $clog2(NFU) : 1;

  logic [NFU-1:0]             hold_vld_q, hold_vld_d;
  logic [NFU-1:0][PR_W-1:0]   hold_tag_q, hold_tag_d;
  logic [NFU-1:0][31:0]       hold_val_q, hold_val_d;
  logic [NCDB-1:0]            cdb_vld_q, cdb_vld_d;
  logic [NCDB-1:0][PR_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [NCDB-1:0][31:0]      cdb_val_q, cdb_val_d;
  logic [NFU-1:0]             grant;
  logic [NCDB-1:0]            lane_vld;
  logic [NCDB-1:0][PTR_W-1:0] lane_idx;
  logic [PTR_W-1:0]           ptr;

  // Scan from ptr upward; the n-th granted FU lands on lane n.
  always_comb begin
    int n;
    logic [PTR_W-1:0] idx;
    grant    = '0;
    lane_vld = '0;
    lane_idx = '0;
    n        = 0;
    idx      = '0;
    for (int k = 0; k < NFU; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NFU);
      if (hold_vld_q[idx] && n < NCDB) begin
        grant[idx] = 1'b1;
        for (int l = 0; l < NCDB; l++) begin
          if (l == n) begin
            lane_vld[l] = 1'b1;
            lane_idx[l] = idx;
          end
        end
        n++;
      end
    end
  end

  assign fu_ready = ~hold_vld_q | grant;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_tag_d = hold_tag_q;
    hold_val_d = hold_val_q;
    for (int i = 0; i < NFU; i++) begin
      if (fu_done[i] && fu_ready[i]) begin
        hold_vld_d[i] = 1'b1;
        hold_tag_d[i] = fu_dest_pr[i];
        hold_val_d[i] = fu_value[i];
      end else if (grant[i]) begin
        hold_vld_d[i] = 1'b0;
      end
    end
  end

  // Idle lanes broadcast all zeros; tag 0 never matches a waiting consumer.
  always_comb begin
    cdb_vld_d = lane_vld;
    cdb_tag_d = '0;
    cdb_val_d = '0;
    for (int l = 0; l < NCDB; l++) begin
      if (lane_vld[l]) begin
        cdb_tag_d[l] = hold_tag_q[lane_idx[l]];
        cdb_val_d[l] = hold_val_q[lane_idx[l]];
      end
    end
  end

`ifdef CDB_ROTATE_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    for (int l = 0; l < NCDB; l++) begin
      if (lane_vld[l]) ptr_d = PTR_W'((int'(lane_idx[l]) + 1) % NFU);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_vld_q <= '0;
      cdb_vld_q  <= '0;
      cdb_tag_q  <= '0;
      cdb_val_q  <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_val_q  <= cdb_val_d;
    end
  end

  always_ff @(posedge clock) begin
    hold_tag_q <= hold_tag_d;
    hold_val_q <= hold_val_d;
  end

  assign cdb_valid = cdb_vld_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_val_q;
  assign pending   = hold_vld_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: reference model of pending results and grant order,
// expected broadcasts queued per cycle and checked by an independent monitor.
module tb_cdb_arbiter;
  localparam int PR_W = 6;
  localparam int NFU  = 8;
  localparam int NCDB = 3;

  logic                      clock;
  logic                      reset;
  logic [NFU-1:0]            fu_done;
  logic [NFU-1:0][PR_W-1:0]  fu_dest_pr;
  logic [NFU-1:0][31:0]      fu_value;
  logic [NFU-1:0]            fu_ready;
  logic [NCDB-1:0]           cdb_valid;
  logic [NCDB-1:0][PR_W-1:0] cdb_tag;
  logic [NCDB-1:0][31:0]     cdb_value;
  logic [NFU-1:0]            pending;

  cdb_arbiter #(.PR_W(PR_W), .NFU(NFU), .NCDB(NCDB)) dut (
    .clock(clock), .reset(reset), .fu_done(fu_done), .fu_dest_pr(fu_dest_pr),
    .fu_value(fu_value), .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .pending(pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int                   cyc;
    bit [2:0]             vld;
    bit [2:0][5:0]        tag;
    bit [2:0][31:0]       val;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  bit            started = 0;
  bit [7:0]      m_vld = '0;
  bit [7:0][5:0] m_tag = '0;
  bit [7:0][31:0] m_val = '0;
  int            m_ptr = 0;
  bit [7:0]      m_gnt_now = '0;
  bit [7:0]      m_rdy = '1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Pick up to three pending FUs, walking upward from the pointer with wraparound.
  function automatic bit [7:0] scan(input bit [7:0] v, input int p, output int ln[$]);
    bit [7:0] g;
    int i;
    g = '0;
    ln.delete();
    for (int k = 0; k < 8; k++) begin
      i = (p + k) % 8;
      if (v[i] && ln.size() < 3) begin
        g[i] = 1'b1;
        ln.push_back(i);
      end
    end
    return g;
  endfunction

  // Reference model, advanced on each rising edge.
  initial begin
    bit [7:0] g;
    int ln[$];
    exp_t e;
    int f;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_vld = '0;
        m_ptr = 0;
        started = 1'b1;
      end else if (started) begin
        g = scan(m_vld, m_ptr, ln);
        if (ln.size() > 0) begin
          e.cyc = cyc; e.vld = '0; e.tag = '0; e.val = '0;
          for (int l = 0; l < ln.size(); l++) begin
            f = ln[l];
            e.vld[l[1:0]] = 1'b1;
            e.tag[l[1:0]] = m_tag[f[2:0]];
            e.val[l[1:0]] = m_val[f[2:0]];
          end
          sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
          if (fu_done[i] && (!m_vld[i] || g[i])) begin
            m_vld[i] = 1'b1;
            m_tag[i] = fu_dest_pr[i];
            m_val[i] = fu_value[i];
          end else if (g[i]) begin
            m_vld[i] = 1'b0;
          end
        end
`ifdef CDB_ROTATE_EN
        if (ln.size() > 0) m_ptr = (ln[ln.size()-1] + 1) % 8;
`endif
      end
      m_gnt_now = scan(m_vld, m_ptr, ln);
      m_rdy     = ~m_vld | m_gnt_now;
    end
  end

  // Monitor: compares DUT outputs with the model on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (started) begin
        chk("fu_ready", fu_ready, m_rdy);
        chk("pending", pending, m_vld);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          chk("missed_broadcast_cycle", 128'(cyc), 128'(sb[0].cyc));
          sb.delete(0);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          chk("cdb_valid", cdb_valid, e.vld);
          chk("cdb_tag", cdb_tag, e.tag);
          chk("cdb_value", cdb_value, e.val);
        end else begin
          chk("idle_cdb", {cdb_valid, cdb_tag, cdb_value}, '0);
        end
      end
    end
  end

  task automatic idle(input int n);
    fu_done = '0;
    repeat (n) @(negedge clock);
  endtask

  task automatic load_all(input int base);
    for (int i = 0; i < 8; i++) begin
      fu_done[i]    = 1'b1;
      fu_dest_pr[i] = 6'(base + i);
      fu_value[i]   = 32'hA000 + 32'(base + i);
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    fu_done = '0;
    fu_dest_pr = '0;
    fu_value = '0;
    repeat (2) @(negedge clock);
    chk("reset_cdb", {cdb_valid, cdb_tag, cdb_value}, '0);
    chk("reset_pending", pending, '0);
    chk("reset_ready", fu_ready, 8'hFF);
    reset = 1'b0;

    // Single result on FU 0
    fu_done[0] = 1'b1; fu_dest_pr[0] = 6'd5; fu_value[0] = 32'h11;
    @(negedge clock);
    idle(5);

    // All eight FUs at once, tags 1..8
    load_all(1);
    @(negedge clock);
    idle(6);

    // FUs 0-2 re-present whenever ready while the rest wait
    load_all(1);
    @(negedge clock);
    for (int t = 0; t < 30; t++) begin
      fu_done = '0;
      for (int i = 0; i < 3; i++) begin
        fu_done[i]    = m_rdy[i];
        fu_dest_pr[i] = 6'(16 + t);
        fu_value[i]   = 32'($urandom);
      end
      @(negedge clock);
    end
    idle(8);

    // Back-to-back on FU 3: tag 10 offered on the edge that grants tag 9
    fu_done[3] = 1'b1; fu_dest_pr[3] = 6'd9; fu_value[3] = 32'h99;
    @(negedge clock);
    fu_done = '0;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (m_gnt_now[3]) begin
        chk("b2b_ready3", fu_ready[3], 1'b1);
        fu_done[3] = 1'b1; fu_dest_pr[3] = 6'd10; fu_value[3] = 32'h1010;
        found = 1'b1;
      end
      @(negedge clock);
      fu_done = '0;
    end
    chk("b2b_grant_seen", found, 1'b1);
    idle(5);

    // Offer to FU 4 while it is still holding an ungranted result
    load_all(20);
    @(negedge clock);
    fu_done = '0;
    fu_done[4] = 1'b1; fu_dest_pr[4] = 6'd33; fu_value[4] = 32'h3333;
    @(negedge clock);
    idle(6);

    // Randomized traffic, tags including 0
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 8; i++) begin
        fu_done[i]    = ($urandom_range(0, 99) < 40);
        fu_dest_pr[i] = 6'($urandom);
        fu_value[i]   = 32'($urandom);
      end
      @(negedge clock);
    end
    idle(8);

    // Reset with eight results pending; done offered during the reset edge
    load_all(40);
    @(negedge clock);
    reset = 1'b1;
    load_all(50);
    @(negedge clock);
    chk("post_reset_pending", pending, '0);
    chk("post_reset_cdb_valid", cdb_valid, '0);
    chk("post_reset_ready", fu_ready, 8'hFF);
    reset = 1'b0;
    idle(10);

    chk("scoreboard_drained", 128'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
